// File: rtl/sevseg_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver: the value load path in,
// and the registered segment, anode and frame-pulse outputs back out.
// Ports: DATA/LOAD/BLANK from the controller; SEV/AN/FRAME_DONE from the driver.
interface sevseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] DATA;        // nibble k drives digit k
  logic                    LOAD;        // single-cycle capture strobe
  logic                    BLANK;       // force display dark
  logic [0:6]              SEV;         // segments a..g, SEV[0]=a
  logic [NUM_DIGITS-1:0]   AN;          // one-hot digit enable
  logic                    FRAME_DONE;  // pulse after each full scan

  modport master (output DATA, LOAD, BLANK, input SEV, AN, FRAME_DONE);
  modport slave  (input DATA, LOAD, BLANK, output SEV, AN, FRAME_DONE);
endinterface

// File: rtl/sevseg_scan_driver.sv
// Multiplexed hex seven-segment driver: prescaled digit scan, tear-free
// shadow->display commit at frame boundaries, optional leading-zero blanking
// (enabled by defining SEVSEG_LZ_SUPPRESS_EN).
// Ports: CLK, RST (async, active-high), bus (slave side of sevseg_scan_driver_if).
// SEV/AN/FRAME_DONE are registered, one cycle behind the scan state.
module sevseg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  sevseg_scan_driver_if.slave  bus
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sevseg_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("sevseg_scan_driver: SCAN_DIV must be >= 1");
  end

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         display;
  logic                  pending;
  logic [0:6]            sev;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_done;

  logic                  tick;
  logic                  last_digit;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  suppress;
  logic [0:6]            sev_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  function automatic logic [0:6] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h73;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      4'hF: decode = 7'h47;
    endcase
  endfunction

  assign tick       = (cnt == CW'(SCAN_DIV - 1));
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));
  assign boundary   = tick && last_digit;

`ifdef SEVSEG_LZ_SUPPRESS_EN
  // A digit is a leading zero when it and every more-significant nibble of
  // the committed display value are zero; digit 0 always shows.
  logic upper_nz;
  always_comb begin
    upper_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && display[4*k +: 4] != 4'h0) upper_nz = 1'b1;
    end
    suppress = (idx != '0) && !upper_nz;
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    nib     = display[4*idx +: 4];
    sev_nxt = decode(nib);
    an_nxt  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) an_nxt[k] = (int'(idx) == k);
    if (bus.BLANK || suppress) begin
      sev_nxt = '0;
      an_nxt  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      display    <= '0;
      pending    <= 1'b0;
      sev        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= last_digit ? '0 : idx + IW'(1);
      frame_done <= boundary;
      // A load landing on the boundary bypasses the shadow so it is not
      // held back a whole frame; otherwise the shadow is committed only at
      // the boundary so a frame never mixes old and new digits.
      if (bus.LOAD) begin
        if (boundary) begin
          display <= bus.DATA;
          pending <= 1'b0;
        end else begin
          shadow  <= bus.DATA;
          pending <= 1'b1;
        end
      end else if (boundary && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
      sev <= sev_nxt;
      an  <= an_nxt;
    end
  end

  assign bus.SEV        = sev;
  assign bus.AN         = an;
  assign bus.FRAME_DONE = frame_done;

endmodule
